mdu_iter: RTL

Iterative multiply/divide unit for the RV32M extension, sitting beside the single-cycle combinational ALU in the execute stage. It accepts the same register-file operands on a start/busy/done handshake. It computes all eight M-extension operations in a fixed number of cycles using one shared 64-bit shift datapath. The control unit stalls the PC while `Busy` is high and writes `Result` back on `Done`.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_iter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants and types for the iterative RV32M multiply/divide unit.
// Holds the funct3 operation codes, the FSM state type and the special-case result words.
package mdu_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [31:0] MD_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] MD_MIN_NEG  = 32'h8000_0000;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, 34 cycles per operation.
// In:  CLK, RST_n, ReadData1 (rs1), ReadData2 (rs2), MDOp (funct3), Start.
// Out: Busy (op in flight), Done (1-cycle pulse), Result (registered), zero (Result==0).
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic [2:0]      MDOp,
    input  logic            Start,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic            zero
);

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic                dz_q, dz_d;
    logic                ovf_q, ovf_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                zero_q, zero_d;
    logic                done_q, done_d;

    // operand decode (used only when a Start is accepted)
    logic            a_sgn, b_sgn;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    // iteration and finish datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, res;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (MDOp)
            MD_MULH, MD_DIV, MD_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            MD_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
        a_neg = a_sgn & ReadData1[XLEN-1];
        b_neg = b_sgn & ReadData2[XLEN-1];
        a_mag = a_neg ? ('0 - ReadData1) : ReadData1;
        b_mag = b_neg ? ('0 - ReadData2) : ReadData2;
    end

    always_comb begin
        // shift-add: acc = {partial, multiplier}, add multiplicand on LSB
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, opb_q} : '0);
        // restoring step on the 33-bit shifted remainder
        div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opb_q};

        prod = neg_q ? ('0 - acc_q) : acc_q;
        quot = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem  = rneg_q ? ('0 - acc_q[2*XLEN-1:XLEN])
                      : acc_q[2*XLEN-1:XLEN];

        res = '0;
        unique case (op_q)
            MD_MUL:                       res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              res = quot;
            MD_REM, MD_REMU:              res = rem;
            default:                      res = '0;
        endcase
        // x/0 leaves rem = |A| with the dividend sign, i.e. A itself,
        // so only the quotient needs forcing.
        if ((op_q == MD_DIV || op_q == MD_DIVU) && dz_q)
            res = MD_ALL_ONES;
        if (op_q == MD_DIV && ovf_q)
            res = MD_MIN_NEG;
        if (op_q == MD_REM && ovf_q)
            res = '0;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d   = MDOp;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    dz_d   = (ReadData2 == '0);
                    ovf_d  = (MDOp == MD_DIV || MDOp == MD_REM)
                           && ReadData1 == MD_MIN_NEG
                           && ReadData2 == MD_ALL_ONES;
                    if (MDOp[2]) begin
                        acc_d = {{XLEN{1'b0}}, a_mag};
                        opb_d = b_mag;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, b_mag};
                        opb_d = a_mag;
                    end
                    cnt_d   = 5'd31;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    if (!div_diff[XLEN+1])
                        acc_d = {div_diff[XLEN-1:0],
                                 acc_q[XLEN-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0)
                    state_d = FIN;
            end
            FIN: begin
                result_d = res;
                zero_d   = (res == '0);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign Busy   = (state_q != IDLE);
    assign Done   = done_q;
    assign Result = result_q;
    assign zero   = zero_q;

endmodule
